sreg_arbiter: RTL and testbench

SREG_ARBITER -- requirements
Module: sreg_arbiter

---
 rtl/sreg_arbiter.sv | 106 ++++++++++
 tb/tb_sreg_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sreg_arbiter.sv
// Arbitrates N_REQ requesters onto a single synchronous special-register ROM; round-robin when SREG_ARB_RR_EN is defined, else fixed priority (lowest index).
// Latency: request sampled at edge k -> gnt pulse in cycle k+1 -> rsp_valid pulse with rsp_data in cycle k+3; one access every 3 cycles.
// Backpressure: none; requesters hold req high until gnt, and a dropped request is simply not arbitrated.
module sreg_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int N_REQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ADDR_W-1:0]       r_addr,
    input  logic [DATA_W-1:0]       data_out
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

    state_t           state_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] win_idx;
    logic             win_found;

`ifdef SREG_ARB_RR_EN
    logic [TAG_W-1:0] ptr_q;
    int               cand;

    // Search starts at the pointer and wraps past the top requester back to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(cand);
            end
        end
    end
`else
    // Scanning downward lets the lowest asserted index overwrite the others.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            r_addr    <= '0;
            tag_q     <= '0;
`ifdef SREG_ARB_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gnt     <= ONE_HOT0 << win_idx;
                        r_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        tag_q   <= win_idx;
`ifdef SREG_ARB_RR_EN
                        ptr_q   <= (win_idx == TAG_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                        state_q <= WAIT;
                    end
                end
                // The ROM samples r_addr at the edge leaving WAIT.
                WAIT: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    rsp_data  <= data_out;
                    rsp_valid <= ONE_HOT0 << tag_q;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sreg_arbiter.sv
// Directed bench for sreg_arbiter with a synchronous ROM model; expectations follow the build (SREG_ARB_RR_EN or fixed priority).
module tb_sreg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [3:0]  r_addr;
    logic [7:0]  data_out;

    logic [7:0]  rom [16];

    int n_chk;
    int n_fail;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] addr;
        logic [3:0]  gnt;
        logic [3:0]  raddr;
        logic [7:0]  data;
    } vec_t;

    vec_t       vecs [6];
    logic [3:0] g_seq [5];
    logic [7:0] d_seq [5];

    sreg_arbiter #(
        .ADDR_W (4),
        .DATA_W (8),
        .N_REQ  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .r_addr    (r_addr),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: {a, ~a}, except address 3 which holds 0xA5.
    initial begin
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'(i), ~4'(i)};
        end
        rom[3] = 8'hA5;
    end

    always @(posedge clk) data_out <= rom[r_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{req: 4'b0001, addr: 16'h0003, gnt: 4'b0001, raddr: 4'h3, data: 8'hA5};
        vecs[1] = '{req: 4'b0100, addr: 16'h0500, gnt: 4'b0100, raddr: 4'h5, data: 8'h5A};
        vecs[2] = '{req: 4'b1000, addr: 16'h9000, gnt: 4'b1000, raddr: 4'h9, data: 8'h96};
        vecs[3] = '{req: 4'b0110, addr: 16'h0740, gnt: 4'b0010, raddr: 4'h4, data: 8'h4B};
`ifdef SREG_ARB_RR_EN
        vecs[4] = '{req: 4'b0101, addr: 16'h0601, gnt: 4'b0100, raddr: 4'h6, data: 8'h69};
`else
        vecs[4] = '{req: 4'b0101, addr: 16'h0601, gnt: 4'b0001, raddr: 4'h1, data: 8'h1E};
`endif
        vecs[5] = '{req: 4'b0010, addr: 16'h00F0, gnt: 4'b0010, raddr: 4'hF, data: 8'hF0};

`ifdef SREG_ARB_RR_EN
        g_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d_seq = '{8'h1E, 8'h2D, 8'h4B, 8'h87, 8'h1E};
`else
        g_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
        d_seq = '{8'h69, 8'h69, 8'h69, 8'h69, 8'h69};
`endif

        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_r_addr", 32'(r_addr), 32'h0);
        rst_n = 1'b1;

        // Single-transaction vectors; the first one is launched right at reset release.
        for (int v = 0; v < 6; v++) begin
            req      = vecs[v].req;
            req_addr = vecs[v].addr;
            @(negedge clk);
            chk("vec_gnt", 32'(gnt), 32'(vecs[v].gnt));
            chk("vec_r_addr", 32'(r_addr), 32'(vecs[v].raddr));
            chk("vec_rsp_data_hold", 32'(rsp_data), (v == 0) ? 32'h0 : 32'(vecs[v-1].data));
            req = '0;
            @(negedge clk);
            chk("vec_gnt_clear", 32'(gnt), 32'h0);
            chk("vec_rsp_valid_early", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            chk("vec_rsp_valid", 32'(rsp_valid), 32'(vecs[v].gnt));
            chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].data));
        end

        // Address change after grant must not disturb the in-flight access.
        req      = 4'b0100;
        req_addr = 16'h0500;
        @(negedge clk);
        chk("addr_gnt", 32'(gnt), 32'h4);
        chk("addr_r_addr", 32'(r_addr), 32'h5);
        req      = '0;
        req_addr = 16'h0900;
        @(negedge clk);
        chk("addr_r_addr_hold", 32'(r_addr), 32'h5);
        @(negedge clk);
        chk("addr_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("addr_rsp_data", 32'(rsp_data), 32'h5A);

        // Requester 2 pulses req only while the arbiter is busy.
        req      = 4'b0001;
        req_addr = 16'h0000;
        @(negedge clk);
        chk("drop_gnt0", 32'(gnt), 32'h1);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("drop_rsp_valid0", 32'(rsp_valid), 32'h1);
        chk("drop_rsp_data0", 32'(rsp_data), 32'h0F);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("drop_no_gnt", 32'(gnt), 32'h0);
            chk("drop_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Asynchronous reset in CAPTURE discards the access.
        req      = 4'b0010;
        req_addr = 16'h0030;
        @(negedge clk);
        chk("rstcap_gnt", 32'(gnt), 32'h2);
        chk("rstcap_r_addr", 32'(r_addr), 32'h3);
        req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstcap_gnt_zero", 32'(gnt), 32'h0);
        chk("rstcap_rsp_valid_zero", 32'(rsp_valid), 32'h0);
        chk("rstcap_rsp_data_zero", 32'(rsp_data), 32'h0);
        chk("rstcap_r_addr_zero", 32'(r_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstcap_no_rsp", 32'(rsp_valid), 32'h0);
            chk("rstcap_no_gnt", 32'(gnt), 32'h0);
        end

        // Held multi-requester pattern right after reset (pointer starts at 0).
`ifdef SREG_ARB_RR_EN
        req      = 4'b1111;
        req_addr = 16'h8421;
`else
        req      = 4'b1010;
        req_addr = 16'h7060;
`endif
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            chk("held_gnt", 32'(gnt), (j % 3 == 1) ? 32'(g_seq[j/3]) : 32'h0);
            chk("held_rsp_valid", 32'(rsp_valid), (j % 3 == 0) ? 32'(g_seq[j/3-1]) : 32'h0);
            if (j % 3 == 0) begin
                chk("held_rsp_data", 32'(rsp_data), 32'(d_seq[j/3-1]));
            end
        end
        req = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
